// File: rtl/uofdm_pkg.sv
// uofdm_pkg: shared sizes, state encodings and DAC constants for the IFFT sink.
// UOFDM_EN selects two-subframe unipolar readout; default build is DCO-OFDM.
package uofdm_pkg;
  localparam int N      = 128;
  localparam int CP_LEN = 16;
  localparam int DW_IN  = 12;
  localparam int DW_OUT = 8;
  localparam int SHIFT  = 4;
  localparam int AW     = $clog2(N);

  localparam logic [DW_OUT-1:0] DAC_MID = DW_OUT'(2 ** (DW_OUT - 1));

  typedef enum logic {W_IDLE, W_FILL} wstate_t;

`ifdef UOFDM_EN
  typedef enum logic [2:0] {
    R_IDLE, R_CP_P, R_BODY_P, R_CP_N, R_BODY_N
  } rstate_t;
`else
  typedef enum logic [1:0] {
    R_IDLE, R_CP_P, R_BODY_P
  } rstate_t;
`endif
endpackage

// File: rtl/uofdm_sample_fmt.sv
// uofdm_sample_fmt: shift/saturate on the way in, DAC mapping on the way out.
// UOFDM_EN: clipped positive/negative halves; otherwise offset binary.
module uofdm_sample_fmt
  import uofdm_pkg::*;
(
  input  logic [DW_IN-1:0]  raw,
  output logic [DW_OUT-1:0] sat,
  input  logic [DW_OUT-1:0] x,
`ifdef UOFDM_EN
  input  logic              neg,
`endif
  output logic [DW_OUT-1:0] dac
);
  localparam logic signed [DW_IN-1:0] HI = DW_IN'(2 ** (DW_OUT - 1) - 1);
  localparam logic signed [DW_IN-1:0] LO = DW_IN'(-(2 ** (DW_OUT - 1)));

  logic signed [DW_IN-1:0] sh;

  assign sh = $signed(raw) >>> SHIFT;

  // clamp the shifted sample into the signed DAC range
  always_comb begin
    if (sh > HI)      sat = HI[DW_OUT-1:0];
    else if (sh < LO) sat = LO[DW_OUT-1:0];
    else              sat = sh[DW_OUT-1:0];
  end

`ifdef UOFDM_EN
  // keep one polarity; the most negative code flips to midscale
  always_comb begin
    if (neg) dac = x[DW_OUT-1] ? -x : '0;
    else     dac = x[DW_OUT-1] ? '0 : x;
  end
`else
  // offset binary: flipping the sign bit adds midscale
  always_comb begin
    dac = x ^ DAC_MID;
  end
`endif
endmodule

// File: rtl/ifft_src_ctrl.sv
// ifft_src_ctrl: IFFT source sink, ping-pong frame store, CP-prefixed DAC stream.
// UOFDM_EN adds the negative subframe (U-OFDM); default is DCO-OFDM.
module ifft_src_ctrl
  import uofdm_pkg::*;
(
  input  logic              wrclock,
  input  logic              reset,
  input  logic              source_valid,
  input  logic              source_sop,
  input  logic              source_eop,
  input  logic [1:0]        source_error,
  input  logic [DW_IN-1:0]  source_real,
  input  logic [DW_IN-1:0]  source_imag,
  output logic              source_ready,
  output logic [DW_OUT-1:0] dac_data,
  output logic              dac_valid,
  output logic              frame_start,
  output logic              frame_err
);
  localparam logic [AW-1:0] LAST     = AW'(N - 1);
  localparam logic [AW-1:0] CP_START = AW'(N - CP_LEN);

  wstate_t w_state, w_nxt;
  rstate_t r_state, r_nxt;

  logic [AW-1:0]     wr_idx, wr_idx_nxt, wr_addr;
  logic [AW-1:0]     rd_idx, rd_idx_nxt;
  logic              wr_bank, rd_bank;
  logic [1:0]        full, set_vec, clr_vec;
  logic [DW_OUT-1:0] mem [2*N];
  logic [DW_OUT-1:0] wr_data, rd_data, dac_map;
  logic              accept, bad, we, set_full, clr_full, drop;
  logic              rd_act, rd_first, rd_last, in_cp, other_full;
`ifdef UOFDM_EN
  logic              rd_neg;
`endif
  logic              unused_imag;

  assign unused_imag  = ^source_imag;
  assign source_ready = !full[wr_bank];
  assign accept       = source_valid & source_ready;
  assign bad          = source_error != 2'b00;
  assign rd_last      = rd_idx == LAST;
  assign other_full   = full[~rd_bank];
  assign set_vec      = {set_full & wr_bank, set_full & ~wr_bank};
  assign clr_vec      = {clr_full & rd_bank, clr_full & ~rd_bank};
  assign rd_data      = mem[{rd_bank, rd_idx}];

  uofdm_sample_fmt u_fmt (
    .raw (source_real),
    .sat (wr_data),
    .x   (rd_data),
`ifdef UOFDM_EN
    .neg (rd_neg),
`endif
    .dac (dac_map)
  );

  // write FSM state, fill index and write bank
  always_ff @(posedge wrclock or negedge reset) begin
    if (!reset) begin
      w_state <= W_IDLE;
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else begin
      w_state <= w_nxt;
      wr_idx  <= wr_idx_nxt;
      if (set_full) wr_bank <= ~wr_bank;
    end
  end

  // write FSM next state: sop always (re)starts, errors and bad eop abort
  always_comb begin
    w_nxt      = w_state;
    wr_idx_nxt = wr_idx;
    if (accept) begin
      if (source_sop) begin
        w_nxt      = (bad || source_eop) ? W_IDLE : W_FILL;
        wr_idx_nxt = AW'(1);
      end else if (w_state == W_FILL) begin
        if (bad || source_eop || wr_idx == LAST) w_nxt = W_IDLE;
        wr_idx_nxt = wr_idx + 1'b1;
      end
    end
  end

  // write FSM outputs: store strobe, bank completion and drop flag
  always_comb begin
    we       = 1'b0;
    wr_addr  = wr_idx;
    set_full = 1'b0;
    drop     = 1'b0;
    if (accept) begin
      if (source_sop) begin
        we      = !bad && !source_eop;
        wr_addr = '0;
        drop    = bad || source_eop || (w_state == W_FILL);
      end else if (w_state == W_FILL) begin
        we       = !bad;
        set_full = !bad && source_eop && wr_idx == LAST;
        drop     = bad || (source_eop != (wr_idx == LAST));
      end
    end
  end

  // sample store; contents need no reset
  always_ff @(posedge wrclock) begin
    if (we) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  // bank full flags; set and clear always target different banks
  always_ff @(posedge wrclock or negedge reset) begin
    if (!reset) full <= '0;
    else        full <= (full | set_vec) & ~clr_vec;
  end

  // read FSM state, read index and read bank
  always_ff @(posedge wrclock or negedge reset) begin
    if (!reset) begin
      r_state <= R_IDLE;
      rd_idx  <= CP_START;
      rd_bank <= 1'b0;
    end else begin
      r_state <= r_nxt;
      rd_idx  <= rd_idx_nxt;
      if (clr_full) rd_bank <= ~rd_bank;
    end
  end

  // read FSM next state; CP wraps into the body, body end reloads the CP start
  always_comb begin
    r_nxt      = r_state;
    rd_idx_nxt = rd_idx;
    unique case (r_state)
      R_IDLE:   if (full[rd_bank]) r_nxt = R_CP_P;
      R_CP_P:   if (rd_last) r_nxt = R_BODY_P;
`ifdef UOFDM_EN
      R_BODY_P: if (rd_last) r_nxt = R_CP_N;
      R_CP_N:   if (rd_last) r_nxt = R_BODY_N;
      R_BODY_N: if (rd_last) r_nxt = other_full ? R_CP_P : R_IDLE;
`else
      R_BODY_P: if (rd_last) r_nxt = other_full ? R_CP_P : R_IDLE;
`endif
      default:  r_nxt = R_IDLE;
    endcase
    if (r_state != R_IDLE)
      rd_idx_nxt = (rd_last && !in_cp) ? CP_START : rd_idx + 1'b1;
  end

  // read FSM outputs: activity, subframe polarity, frame start, release
  always_comb begin
    rd_act   = r_state != R_IDLE;
    rd_first = r_state == R_CP_P && rd_idx == CP_START;
`ifdef UOFDM_EN
    in_cp    = r_state == R_CP_P || r_state == R_CP_N;
    rd_neg   = r_state == R_CP_N || r_state == R_BODY_N;
    clr_full = rd_last && r_state == R_BODY_N;
`else
    in_cp    = r_state == R_CP_P;
    clr_full = rd_last && r_state == R_BODY_P;
`endif
  end

  // registered DAC stream and status pulses
  always_ff @(posedge wrclock or negedge reset) begin
    if (!reset) begin
      dac_data    <= '0;
      dac_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      dac_data    <= rd_act ? dac_map : '0;
      dac_valid   <= rd_act;
      frame_start <= rd_first;
      frame_err   <= drop;
    end
  end
endmodule

// File: tb/tb_ifft_src_ctrl.sv
// tb_ifft_src_ctrl: directed frames against a scoreboard of hand-derived samples.
// Expected stream follows UOFDM_EN when the bench is built with it.
module tb_ifft_src_ctrl;
  localparam int N  = 128;
  localparam int CP = 16;
`ifdef UOFDM_EN
  localparam int SUBS = 2;
`else
  localparam int SUBS = 1;
`endif
  localparam int FR = SUBS * (CP + N);

  typedef struct packed {
    logic [7:0] d;
    logic       s;
  } exp_t;

  typedef struct {
    logic [11:0] in;
    int          pos;
    int          neg;
    int          off;
  } vec_t;

  logic        wrclock = 1'b0;
  logic        reset = 1'b0;
  logic        source_valid = 1'b0;
  logic        source_sop = 1'b0;
  logic        source_eop = 1'b0;
  logic [1:0]  source_error = 2'b00;
  logic [11:0] source_real = '0;
  logic [11:0] source_imag = '0;
  logic        source_ready;
  logic [7:0]  dac_data;
  logic        dac_valid;
  logic        frame_start;
  logic        frame_err;

  exp_t q[$];
  vec_t tbl[12];
  int   checks = 0;
  int   errors = 0;
  int   samples = 0;
  int   gaps = 0;
  int   errs_seen = 0;
  int   stalls = 0;

  ifft_src_ctrl dut (
    .wrclock      (wrclock),
    .reset        (reset),
    .source_valid (source_valid),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_error (source_error),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .source_ready (source_ready),
    .dac_data     (dac_data),
    .dac_valid    (dac_valid),
    .frame_start  (frame_start),
    .frame_err    (frame_err)
  );

  always #5 wrclock = ~wrclock;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge wrclock);
      if (reset) begin
        if (frame_err) errs_seen++;
        if (dac_valid) begin
          samples++;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL extra_sample got %0d expected none", dac_data);
          end else begin
            e = q.pop_front();
            if (dac_data !== e.d || frame_start !== e.s) begin
              errors++;
              $display("FAIL sample got %0d/%0b expected %0d/%0b",
                       dac_data, frame_start, e.d, e.s);
            end
          end
        end else if (frame_start) begin
          checks++;
          errors++;
          $display("FAIL start_no_valid got 1 expected 0");
        end
        if (prev && !dac_valid && q.size() != 0) gaps++;
        prev = dac_valid;
      end else begin
        prev = 1'b0;
      end
    end
  endtask

  task automatic push_frame(input bit ramp, input int pos, input int neg,
                            input int off);
    exp_t e;
    int   idx;
    int   d;
    for (int sub = 0; sub < SUBS; sub++) begin
      for (int j = 0; j < CP + N; j++) begin
        idx = (j < CP) ? N - CP + j : j - CP;
        if (ramp) d = (SUBS == 2) ? ((sub == 0) ? idx : 0) : 128 + idx;
        else      d = (SUBS == 2) ? ((sub == 0) ? pos : neg) : off;
        e.d = 8'(d);
        e.s = (sub == 0 && j == 0);
        q.push_back(e);
      end
    end
  endtask

  task automatic beat(input logic [11:0] v, input logic s, input logic e,
                      input logic [1:0] er);
    int t = 0;
    @(negedge wrclock);
    source_valid = 1'b1;
    source_sop   = s;
    source_eop   = e;
    source_error = er;
    source_real  = v;
    source_imag  = ~v;
    #1;
    while (!source_ready && t < 3000) begin
      @(negedge wrclock);
      #1;
      t++;
      stalls++;
    end
    if (t >= 3000) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input bit ramp, input logic [11:0] cv, input int nb,
                      input int eop_at, input int err_at);
    logic [11:0] v;
    for (int k = 0; k < nb; k++) begin
      v = ramp ? 12'(16 * k) : cv;
      beat(v, k == 0, k == eop_at, (k == err_at) ? 2'd1 : 2'd0);
    end
  endtask

  task automatic idle();
    @(negedge wrclock);
    source_valid = 1'b0;
    source_sop   = 1'b0;
    source_eop   = 1'b0;
    source_error = 2'b00;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((q.size() != 0 || dac_valid) && t < 6000) begin
      @(negedge wrclock);
      t++;
    end
    if (t >= 6000) chk(nm, q.size(), 0);
    repeat (2) @(negedge wrclock);
  endtask

  initial begin
    int s0;
    int e0;
    int st;
    int t;
    tbl[0]  = '{12'(0),     0,   0, 128};
    tbl[1]  = '{12'(16),    1,   0, 129};
    tbl[2]  = '{12'(-16),   0,   1, 127};
    tbl[3]  = '{12'(2047),  127, 0, 255};
    tbl[4]  = '{12'(-2048), 0, 128, 0};
    tbl[5]  = '{12'(15),    0,   0, 128};
    tbl[6]  = '{12'(-1),    0,   1, 127};
    tbl[7]  = '{12'(100),   6,   0, 134};
    tbl[8]  = '{12'(-100),  0,   7, 121};
    tbl[9]  = '{12'(1000),  62,  0, 190};
    tbl[10] = '{12'(-1000), 0,  63, 65};
    tbl[11] = '{12'(-17),   0,   2, 126};

    fork
      monitor();
    join_none

    repeat (3) @(negedge wrclock);
    chk("rst_ready", source_ready, 1);
    chk("rst_valid", dac_valid, 0);
    chk("rst_data", dac_data, 0);
    chk("rst_start", frame_start, 0);
    chk("rst_err", frame_err, 0);
    #2 reset = 1'b1;
    repeat (2) @(negedge wrclock);

    s0 = samples;
    push_frame(1, 0, 0, 0);
    send(1, '0, N, N - 1, -1);
    idle();
    drain("ramp_drain");
    chk("ramp_cnt", samples - s0, FR);

    for (int i = 0; i < 12; i++) begin
      s0 = samples;
      push_frame(0, tbl[i].pos, tbl[i].neg, tbl[i].off);
      send(0, tbl[i].in, N, N - 1, -1);
      idle();
      drain("tbl_drain");
      chk("tbl_cnt", samples - s0, FR);
    end

    e0 = errs_seen;
    s0 = samples;
    send(1, '0, 64, 63, -1);
    idle();
    push_frame(1, 0, 0, 0);
    send(1, '0, N, N - 1, -1);
    idle();
    drain("early_drain");
    chk("early_err", errs_seen - e0, 1);
    chk("early_cnt", samples - s0, FR);

    e0 = errs_seen;
    s0 = samples;
    send(1, '0, N, N - 1, 50);
    idle();
    repeat (300) @(negedge wrclock);
    chk("poison_err", errs_seen - e0, 1);
    chk("poison_cnt", samples - s0, 0);
    chk("poison_ready", source_ready, 1);

    e0 = errs_seen;
    s0 = samples;
    send(1, '0, 40, -1, -1);
    push_frame(0, tbl[7].pos, tbl[7].neg, tbl[7].off);
    send(0, tbl[7].in, N, N - 1, -1);
    idle();
    drain("restart_drain");
    chk("restart_err", errs_seen - e0, 1);
    chk("restart_cnt", samples - s0, FR);

    e0 = errs_seen;
    s0 = samples;
    send(1, '0, N + 2, -1, -1);
    idle();
    repeat (300) @(negedge wrclock);
    chk("noeop_err", errs_seen - e0, 1);
    chk("noeop_cnt", samples - s0, 0);

    e0 = errs_seen;
    s0 = samples;
    st = stalls;
    gaps = 0;
    for (int f = 0; f < 4; f++) begin
      if (f[0]) push_frame(0, tbl[4].pos, tbl[4].neg, tbl[4].off);
      else      push_frame(1, 0, 0, 0);
    end
    for (int f = 0; f < 4; f++) begin
      if (f[0]) send(0, tbl[4].in, N, N - 1, -1);
      else      send(1, '0, N, N - 1, -1);
    end
    idle();
    drain("b2b_drain");
    chk("b2b_cnt", samples - s0, 4 * FR);
    chk("b2b_gaps", gaps, 0);
    chk("b2b_stall", int'(stalls > st), 1);
    chk("b2b_err", errs_seen - e0, 0);

    s0 = samples;
    push_frame(1, 0, 0, 0);
    send(1, '0, N, N - 1, -1);
    idle();
    t = 0;
    while (samples < s0 + 100 && t < 3000) begin
      @(negedge wrclock);
      t++;
    end
    chk("rst_reach", int'(samples >= s0 + 100), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", dac_valid, 0);
    chk("mid_rst_start", frame_start, 0);
    chk("mid_rst_ready", source_ready, 1);
    q.delete();
    repeat (2) @(negedge wrclock);
    #2 reset = 1'b1;

    send(1, '0, 20, -1, -1);
    idle();
    #2 reset = 1'b0;
    #1 chk("part_rst_ready", source_ready, 1);
    @(negedge wrclock);
    #2 reset = 1'b1;

    e0 = errs_seen;
    s0 = samples;
    push_frame(1, 0, 0, 0);
    send(1, '0, N, N - 1, -1);
    idle();
    drain("post_rst_drain");
    chk("post_rst_cnt", samples - s0, FR);
    chk("post_rst_err", errs_seen - e0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
